// File: rtl/stopwatch_core.sv
// BCD MM:SS stopwatch core with run, pause and adjust modes. It turns the divided clock
// levels into single-cycle enables using a one-cycle history register per input.
module stopwatch_core #(
    parameter int MIN_LIMIT = 59,
    parameter int SEC_LIMIT = 59
) (
    input  logic       master_clock,
    input  logic       rst,
    input  logic       clock1hz,
    input  logic       clock2hz,
    input  logic       clock_adjust,
    input  logic       pause_pulse,
    input  logic       adj,
    input  logic       sel,
    output logic [3:0] min_tens,
    output logic [3:0] min_ones,
    output logic [3:0] sec_tens,
    output logic [3:0] sec_ones,
    output logic       paused,
    output logic       blink
);

    typedef enum logic [1:0] {
        ST_RUN    = 2'd0,
        ST_PAUSED = 2'd1,
        ST_ADJUST = 2'd2
    } state_t;

    state_t     state_r;
    state_t     state_next_s;
    logic       clk1_hist_r;
    logic       clk2_hist_r;
    logic       tick_s;
    logic       adj_tick_s;
    logic       run_count_s;
    logic       adj_min_s;
    logic       adj_sec_s;
    logic       blink_next_s;
    logic [8:0] sec_inc_s;
    logic [8:0] min_inc_s;

    // Returns {wrapped, tens, ones}; the field wraps to 00 once it reaches the limit.
    function automatic logic [8:0] bcd_inc(input logic [3:0] tens, input logic [3:0] ones,
                                           input logic [7:0] limit);
        logic [7:0] value;
        value = 8'(tens) * 8'd10 + 8'(ones);
        if (value == limit) begin
            bcd_inc = {1'b1, 4'd0, 4'd0};
        end else if (ones == 4'd9) begin
            bcd_inc = {1'b0, tens + 4'd1, 4'd0};
        end else begin
            bcd_inc = {1'b0, tens, ones + 4'd1};
        end
    endfunction

    assign tick_s     = clock1hz & ~clk1_hist_r;
    assign adj_tick_s = clock2hz & ~clk2_hist_r;
    assign sec_inc_s  = bcd_inc(sec_tens, sec_ones, 8'(SEC_LIMIT));
    assign min_inc_s  = bcd_inc(min_tens, min_ones, 8'(MIN_LIMIT));

    // State register and input edge history.
    always_ff @(posedge master_clock) begin
        if (rst) begin
            state_r     <= ST_RUN;
            clk1_hist_r <= 1'b0;
            clk2_hist_r <= 1'b0;
        end else begin
            state_r     <= state_next_s;
            clk1_hist_r <= clock1hz;
            clk2_hist_r <= clock2hz;
        end
    end

    // Next-state logic; leaving ADJUST honours any pause toggled while adjusting.
    always_comb begin
        state_next_s = state_r;
        if (adj) begin
            state_next_s = ST_ADJUST;
        end else begin
            case (state_r)
                ST_RUN:    state_next_s = pause_pulse ? ST_PAUSED : ST_RUN;
                ST_PAUSED: state_next_s = pause_pulse ? ST_RUN : ST_PAUSED;
                ST_ADJUST: state_next_s = (paused ^ pause_pulse) ? ST_PAUSED : ST_RUN;
                default:   state_next_s = ST_RUN;
            endcase
        end
    end

    // Output decode: events are qualified by the current (pre-transition) state.
    always_comb begin
        run_count_s  = 1'b0;
        adj_min_s    = 1'b0;
        adj_sec_s    = 1'b0;
        case (state_r)
            ST_RUN: run_count_s = tick_s;
            ST_ADJUST: begin
                adj_min_s = adj_tick_s & ~sel;
                adj_sec_s = adj_tick_s & sel;
            end
            default: run_count_s = 1'b0;
        endcase
        blink_next_s = (state_next_s == ST_ADJUST) ? clock_adjust : 1'b0;
    end

    // Pause flag and blink output.
    always_ff @(posedge master_clock) begin
        if (rst) begin
            paused <= 1'b0;
            blink  <= 1'b0;
        end else begin
            if (pause_pulse) begin
                paused <= ~paused;
            end
            blink <= blink_next_s;
        end
    end

    // BCD count: seconds carry into minutes while running; adjust steps never carry.
    always_ff @(posedge master_clock) begin
        if (rst) begin
            min_tens <= 4'd0;
            min_ones <= 4'd0;
            sec_tens <= 4'd0;
            sec_ones <= 4'd0;
        end else if (run_count_s) begin
            {sec_tens, sec_ones} <= sec_inc_s[7:0];
            if (sec_inc_s[8]) begin
                {min_tens, min_ones} <= min_inc_s[7:0];
            end
        end else if (adj_min_s) begin
            {min_tens, min_ones} <= min_inc_s[7:0];
        end else if (adj_sec_s) begin
            {sec_tens, sec_ones} <= sec_inc_s[7:0];
        end
    end

endmodule

// File: tb/tb_stopwatch_core.sv
// Directed bench for stopwatch_core: a vector table for run/pause sequencing plus
// hand-written sequences for adjust, simultaneous events and reset.
module tb_stopwatch_core;

    logic       master_clock = 1'b0;
    logic       rst          = 1'b1;
    logic       clock1hz     = 1'b0;
    logic       clock2hz     = 1'b0;
    logic       clock_adjust = 1'b0;
    logic       pause_pulse  = 1'b0;
    logic       adj          = 1'b0;
    logic       sel          = 1'b0;
    logic [3:0] min_tens, min_ones, sec_tens, sec_ones;
    logic       paused, blink;

    int checks   = 0;
    int failures = 0;

    typedef struct {
        logic       c1;
        logic       pp;
        logic       adj;
        logic [7:0] mm;
        logic [7:0] ss;
        logic       p;
    } vec_t;

    vec_t vecs[23];

    stopwatch_core dut (
        .master_clock(master_clock),
        .rst(rst),
        .clock1hz(clock1hz),
        .clock2hz(clock2hz),
        .clock_adjust(clock_adjust),
        .pause_pulse(pause_pulse),
        .adj(adj),
        .sel(sel),
        .min_tens(min_tens),
        .min_ones(min_ones),
        .sec_tens(sec_tens),
        .sec_ones(sec_ones),
        .paused(paused),
        .blink(blink)
    );

    always #5 master_clock = ~master_clock;

    task automatic step();
        @(posedge master_clock);
        #1;
    endtask

    task automatic tick1();
        clock1hz = 1'b1;
        step();
        clock1hz = 1'b0;
        step();
    endtask

    task automatic adj_step(input int n);
        for (int k = 0; k < n; k++) begin
            clock2hz = 1'b1;
            step();
            clock2hz = 1'b0;
            step();
        end
    endtask

    function automatic logic [7:0] to_bcd(input int v);
        to_bcd = {4'(v / 10), 4'(v % 10)};
    endfunction

    task automatic check(input string name, input logic [7:0] mm, input logic [7:0] ss,
                         input logic p);
        checks++;
        if ({min_tens, min_ones} !== mm || {sec_tens, sec_ones} !== ss || paused !== p) begin
            failures++;
            $display("FAIL %s: got %h%h:%h%h paused=%b, expected %h:%h paused=%b",
                     name, min_tens, min_ones, sec_tens, sec_ones, paused, mm, ss, p);
        end
    endtask

    task automatic check_blink(input string name, input logic exp);
        checks++;
        if (blink !== exp) begin
            failures++;
            $display("FAIL %s: got blink=%b, expected %b", name, blink, exp);
        end
    endtask

    task automatic put(input int i, input logic c1, input logic pp, input logic a,
                       input logic [7:0] mm, input logic [7:0] ss, input logic p);
        vecs[i] = '{c1, pp, a, mm, ss, p};
    endtask

    initial begin
        // Table starts in ADJUST at 59:58 (sel=1), exits, rolls over, pauses, resumes.
        put(0, 1'b0, 1'b0, 1'b0, 8'h59, 8'h58, 1'b0);
        put(1, 1'b1, 1'b0, 1'b0, 8'h59, 8'h59, 1'b0);
        put(2, 1'b0, 1'b0, 1'b0, 8'h59, 8'h59, 1'b0);
        put(3, 1'b1, 1'b0, 1'b0, 8'h00, 8'h00, 1'b0);
        put(4, 1'b0, 1'b0, 1'b0, 8'h00, 8'h00, 1'b0);
        put(5, 1'b0, 1'b1, 1'b0, 8'h00, 8'h00, 1'b1);
        for (int i = 6; i < 16; i++) put(i, 1'((i + 1) % 2), 1'b0, 1'b0, 8'h00, 8'h00, 1'b1);
        put(16, 1'b0, 1'b1, 1'b0, 8'h00, 8'h00, 1'b0);
        put(17, 1'b1, 1'b0, 1'b0, 8'h00, 8'h01, 1'b0);
        put(18, 1'b0, 1'b0, 1'b0, 8'h00, 8'h01, 1'b0);
        put(19, 1'b1, 1'b0, 1'b0, 8'h00, 8'h02, 1'b0);
        put(20, 1'b0, 1'b0, 1'b0, 8'h00, 8'h02, 1'b0);
        put(21, 1'b1, 1'b0, 1'b0, 8'h00, 8'h03, 1'b0);
        put(22, 1'b0, 1'b0, 1'b0, 8'h00, 8'h03, 1'b0);

        step();
        step();
        rst = 1'b0;
        check("reset", 8'h00, 8'h00, 1'b0);
        check_blink("reset_blink", 1'b0);

        // 60 ticks: each rise must be visible right after the next active edge.
        for (int i = 1; i <= 60; i++) begin
            clock1hz = 1'b1;
            step();
            check($sformatf("run_tick%0d", i), to_bcd(i / 60), to_bcd(i % 60), 1'b0);
            clock1hz = 1'b0;
            step();
        end

        // Preload 59:58 through ADJUST from a fresh reset.
        rst = 1'b1;
        step();
        rst = 1'b0;
        adj = 1'b1;
        sel = 1'b0;
        step();
        adj_step(59);
        sel = 1'b1;
        adj_step(58);
        check("preload", 8'h59, 8'h58, 1'b0);
        adj = 1'b0;

        for (int i = 0; i < 23; i++) begin
            clock1hz    = vecs[i].c1;
            pause_pulse = vecs[i].pp;
            adj         = vecs[i].adj;
            step();
            check($sformatf("vec%0d", i), vecs[i].mm, vecs[i].ss, vecs[i].p);
        end
        clock1hz    = 1'b0;
        pause_pulse = 1'b0;

        // Tick and pause in the same cycle: counts once, then pauses.
        for (int i = 0; i < 7; i++) tick1();
        check("run_to_10", 8'h00, 8'h10, 1'b0);
        clock1hz    = 1'b1;
        pause_pulse = 1'b1;
        step();
        clock1hz    = 1'b0;
        pause_pulse = 1'b0;
        check("tick_with_pause", 8'h00, 8'h11, 1'b1);
        step();
        tick1();
        check("paused_after_simul", 8'h00, 8'h11, 1'b1);

        // Resume, then toggle pause inside ADJUST: exit must land in PAUSED.
        pause_pulse = 1'b1;
        step();
        pause_pulse = 1'b0;
        check("resumed", 8'h00, 8'h11, 1'b0);
        adj = 1'b1;
        step();
        pause_pulse = 1'b1;
        step();
        pause_pulse = 1'b0;
        check("pause_in_adjust", 8'h00, 8'h11, 1'b1);
        adj = 1'b0;
        step();
        tick1();
        tick1();
        check("exit_to_paused", 8'h00, 8'h11, 1'b1);

        // Seconds adjust wraps without carry; 1 Hz ticks are ignored; blink follows.
        adj = 1'b1;
        sel = 1'b1;
        step();
        adj_step(48);
        check("adj_sec_59", 8'h00, 8'h59, 1'b1);
        adj_step(1);
        check("adj_sec_wrap", 8'h00, 8'h00, 1'b1);
        tick1();
        tick1();
        check("adj_ignores_1hz", 8'h00, 8'h00, 1'b1);
        clock_adjust = 1'b1;
        step();
        check_blink("blink_high", 1'b1);
        clock_adjust = 1'b0;
        step();
        check_blink("blink_low", 1'b0);
        clock_adjust = 1'b1;
        sel = 1'b0;
        adj_step(58);
        check("adj_min_58", 8'h58, 8'h00, 1'b1);
        adj_step(3);
        check("adj_min_wrap", 8'h01, 8'h00, 1'b1);
        check_blink("blink_high2", 1'b1);

        // Preload 12:34, leave ADJUST (still paused) and reset with a coincident tick.
        adj_step(11);
        sel = 1'b1;
        adj_step(34);
        check("preload_1234", 8'h12, 8'h34, 1'b1);
        adj = 1'b0;
        step();
        check_blink("blink_off_exit", 1'b0);
        rst      = 1'b1;
        clock1hz = 1'b1;
        step();
        rst      = 1'b0;
        clock1hz = 1'b0;
        step();
        check("reset_mid", 8'h00, 8'h00, 1'b0);
        check_blink("reset_mid_blink", 1'b0);
        tick1();
        check("after_reset_tick", 8'h00, 8'h01, 1'b0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
